// File: rtl/sdram_arbit.sv
// sdram_arbit: fixed-priority arbiter that hands the SDRAM command bus to the
// init, auto-refresh, write or read engine. Priority is refresh > write > read.
// Each granted engine owns the bus until it raises its end flag. The arbiter
// then spends at least one NOP cycle in ARBIT before issuing the next grant.
module sdram_arbit #(
  parameter int ADDR_W = 13,
  parameter int BANK_W = 2,
  parameter int DATA_W = 16
) (
  input  logic              arb_clk,
  input  logic              arb_rst_n,
  // initialization engine
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [BANK_W-1:0] init_bank,
  input  logic [ADDR_W-1:0] init_addr,
  // auto-refresh engine
  input  logic              ar_req,
  input  logic              ar_end,
  input  logic [3:0]        ar_cmd,
  input  logic [BANK_W-1:0] ar_bank,
  input  logic [ADDR_W-1:0] ar_addr,
  // write engine
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_sdram_en,
  input  logic [DATA_W-1:0] wr_sdram_data,
  // read engine
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [BANK_W-1:0] rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  // grants
  output logic              ar_en,
  output logic              wr_en,
  output logic              rd_en,
  // SDRAM pins
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [BANK_W-1:0] sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [DATA_W-1:0] sdram_dq_out,
  output logic              sdram_dq_oe
);

  // {cs_n, ras_n, cas_n, we_n} for a NOP: chip selected, no operation
  localparam logic [3:0] CMD_NOP = 4'b0111;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARBIT = 3'd1,
    AREF  = 3'd2,
    WRITE = 3'd3,
    READ  = 3'd4
  } state_t;

  state_t            state_reg;
  logic              ar_en_reg;
  logic              wr_en_reg;
  logic              rd_en_reg;
  logic              cke_reg;

  logic [3:0]        cmd_mux;
  logic [BANK_W-1:0] ba_mux;
  logic [ADDR_W-1:0] addr_mux;
  logic              dq_oe_int;

  // Arbitration FSM. Each grant flop is updated on the same transition that
  // enters or leaves its state, so a grant always equals the state decode.
  always_ff @(posedge arb_clk or negedge arb_rst_n) begin
    if (!arb_rst_n) begin
      state_reg <= IDLE;
      ar_en_reg <= 1'b0;
      wr_en_reg <= 1'b0;
      rd_en_reg <= 1'b0;
      cke_reg   <= 1'b0;
    end else begin
      cke_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (init_end) begin
            state_reg <= ARBIT;
          end
        end
        ARBIT: begin
          // Fixed priority; a lower request waits while a higher one is present
          if (ar_req) begin
            state_reg <= AREF;
            ar_en_reg <= 1'b1;
          end else if (wr_req) begin
            state_reg <= WRITE;
            wr_en_reg <= 1'b1;
          end else if (rd_req) begin
            state_reg <= READ;
            rd_en_reg <= 1'b1;
          end
        end
        AREF: begin
          if (ar_end) begin
            state_reg <= ARBIT;
            ar_en_reg <= 1'b0;
          end
        end
        WRITE: begin
          if (wr_end) begin
            state_reg <= ARBIT;
            wr_en_reg <= 1'b0;
          end
        end
        READ: begin
          if (rd_end) begin
            state_reg <= ARBIT;
            rd_en_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          ar_en_reg <= 1'b0;
          wr_en_reg <= 1'b0;
          rd_en_reg <= 1'b0;
        end
      endcase
    end
  end

  // Command/bank/address mux. It follows the current owner with no extra
  // latency, because each engine already times its commands cycle-exactly.
  always_comb begin
    cmd_mux  = init_cmd;
    ba_mux   = init_bank;
    addr_mux = init_addr;
    case (state_reg)
      IDLE: begin
        cmd_mux  = init_cmd;
        ba_mux   = init_bank;
        addr_mux = init_addr;
      end
      ARBIT: begin
        cmd_mux  = CMD_NOP;
        ba_mux   = '1;
        addr_mux = '1;
      end
      AREF: begin
        cmd_mux  = ar_cmd;
        ba_mux   = ar_bank;
        addr_mux = ar_addr;
      end
      WRITE: begin
        cmd_mux  = wr_cmd;
        ba_mux   = wr_bank;
        addr_mux = wr_addr;
      end
      READ: begin
        cmd_mux  = rd_cmd;
        ba_mux   = rd_bank;
        addr_mux = rd_addr;
      end
      default: begin
        cmd_mux  = CMD_NOP;
        ba_mux   = '1;
        addr_mux = '1;
      end
    endcase
  end

  // The data bus is driven only while the write engine owns it and flags
  // valid data. Otherwise it is held at zero so the external buffer idles cleanly.
  assign dq_oe_int    = (state_reg == WRITE) && wr_sdram_en;
  assign sdram_dq_oe  = dq_oe_int;
  assign sdram_dq_out = dq_oe_int ? wr_sdram_data : '0;

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_mux;
  assign sdram_ba   = ba_mux;
  assign sdram_addr = addr_mux;

  assign ar_en     = ar_en_reg;
  assign wr_en     = wr_en_reg;
  assign rd_en     = rd_en_reg;
  assign sdram_cke = cke_reg;

endmodule

// File: doc/sdram_arbit.md
SDRAM_ARBIT -- requirements
Module: sdram_arbit

Interface
REQ-001 Parameters, one per line: ADDR_W, 13, SDRAM row/column address width.
REQ-002 BANK_W, 2, bank address width.
REQ-003 DATA_W, 16, SDRAM data bus width.
REQ-004 arb_clk  input  1  single system clock (100 MHz); all logic on rising edge.
REQ-005 arb_rst_n  input  1  asynchronous reset, active-low.
REQ-006 init_end  input  1  initialization complete flag from sdram_init.
REQ-007 init_cmd / init_bank / init_addr  input  4 / BANK_W / ADDR_W  initialization command, bank and address.
REQ-008 ar_req  input  1  auto-refresh request; ar_end  input  1  refresh done.
REQ-009 ar_cmd / ar_bank / ar_addr  input  4 / BANK_W / ADDR_W  refresh command, bank and address.
REQ-010 wr_req, wr_end  input  1 each  write request and write done.
REQ-011 wr_cmd / wr_bank / wr_addr  input  4 / BANK_W / ADDR_W  write command, bank and address.
REQ-012 wr_sdram_en  input  1  write data valid; wr_sdram_data  input  DATA_W  write data.
REQ-013 rd_req, rd_end  input  1 each  read request and read done.
REQ-014 rd_cmd / rd_bank / rd_addr  input  4 / BANK_W / ADDR_W  read command, bank and address.
REQ-015 ar_en, wr_en, rd_en  output  1 each  grant to the refresh, write and read engines.
REQ-016 sdram_cke  output  1; sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  output  1 each; sdram_ba  output  BANK_W; sdram_addr  output  ADDR_W.
REQ-017 sdram_dq_out  output  DATA_W; sdram_dq_oe  output  1  data bus drive and output enable; the tri-state buffer sits outside this block.

Function
REQ-018 States: IDLE, ARBIT, AREF, WRITE, READ; state register only, clocked on arb_clk.
REQ-019 IDLE -> ARBIT on the first edge with init_end=1.
- After leaving IDLE, init_end is ignored.
REQ-020 ARBIT: fixed priority ar_req > wr_req > rd_req.
- Next state is AREF, WRITE or READ respectively.
- With no request, the block stays in ARBIT.
REQ-021 AREF -> ARBIT on the edge ar_end=1 is sampled; WRITE -> ARBIT on wr_end=1; READ -> ARBIT on rd_end=1.
- Any other end flag and all requests are ignored while busy.
REQ-022 ar_en = (state==AREF), wr_en = (state==WRITE), rd_en = (state==READ), decoded from the state register.
- A grant rises the cycle after its request is sampled in ARBIT.
- A grant falls the cycle after its end flag is sampled.
- At most one grant is ever high.
REQ-023 Back-to-back operations are separated by at least one ARBIT cycle, during which all grants are low.
REQ-024 {cs_n, ras_n, cas_n, we_n}, sdram_ba and sdram_addr are selected combinationally from the state:
- IDLE: init_*.
- ARBIT: NOP 4'b0111, ba all-ones, addr all-ones.
- AREF: ar_*.
- WRITE: wr_*.
- READ: rd_*.
REQ-025 sdram_cke is constant 1 outside reset.
REQ-026 sdram_dq_oe = (state==WRITE) & wr_sdram_en.
- sdram_dq_out = wr_sdram_data when sdram_dq_oe=1, else 0.
REQ-027 A pending lower-priority request (held high by its engine) is serviced in the first ARBIT cycle in which no higher-priority request is present.
REQ-028 An end flag arriving in ARBIT or IDLE has no effect.

Reset
REQ-029 arb_rst_n=0 forces state to IDLE immediately, including mid-operation.
- While held in reset: ar_en=wr_en=rd_en=0, sdram_cke=0, sdram_dq_oe=0, sdram_dq_out=0.
- Command, bank and address outputs follow init_*.
REQ-030 After reset release, the block re-enters ARBIT only after init_end=1 is sampled again.

Verification
REQ-031 Reset, then init_end=1 at cycle 20 with no requests -> IDLE for cycles 0-20, ARBIT from cycle 21; outputs 4'b0111 / 2'b11 / 13'h1FFF; all grants 0.
REQ-032 ar_req=1 in ARBIT, ar_end pulsed 10 cycles after ar_en rises:
- ar_en high exactly 11 cycles.
- sdram_* outputs equal ar_* throughout.
- Return to ARBIT.
REQ-033 ar_req=wr_req=rd_req=1 simultaneously, each engine ends after 5 cycles of grant:
- Grant order ar_en, wr_en, rd_en.
- One ARBIT NOP cycle between each grant.
- No grant overlap.
REQ-034 In WRITE with wr_sdram_en=1 and wr_sdram_data=16'hA5A5 -> sdram_dq_oe=1, sdram_dq_out=16'hA5A5; wr_sdram_en=0 -> sdram_dq_oe=0, sdram_dq_out=0.
REQ-035 ar_req asserted while in READ -> ignored until rd_end; the next ARBIT cycle grants ar_en.
REQ-036 arb_rst_n pulsed low while wr_en=1:
- Immediately state=IDLE, all grants 0, sdram_cke=0.
- After release, no grant until init_end=1 is sampled.
